// File: rtl/imm_gen_if.sv
// Handshake bus for imm_gen_pipe: instruction/tag in, decoded immediate/format/tag out.
// master = upstream/downstream environment side, slave = the decoder pipeline.
interface imm_gen_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with one registered output stage and valid/ready flow control.
// Optional one-entry skid buffer enabled by defining IMM_GEN_PIPE_SKID_EN.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input logic      clk,
    input logic      rst_n,
    imm_gen_if.slave bus
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } res_t;

    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return {{(XLEN-31){v[31]}}, v[30:0]};
    endfunction

    // Shift-immediate forms carry funct7 in the upper bits; only the shamt is returned.
    function automatic logic signed [31:0] shamt_imm(input logic [31:0] instr);
        logic signed [31:0] s;
        if (XLEN == 64) s = {26'b0, instr[25:20]};
        else            s = {27'b0, instr[24:20]};
        return s;
    endfunction

    function automatic res_t decode(input logic [31:0] instr, input logic [TAG_W-1:0] tag);
        res_t               r;
        logic signed [31:0] imm32;
        imm32     = '0;
        r.fmt     = FMT_R;
        r.illegal = 1'b0;
        r.tag     = tag;
        case (instr[6:0])
            7'b0010011: begin
                r.fmt = FMT_I;
                if (instr[13:12] == 2'b01) imm32 = shamt_imm(instr);
                else                       imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            7'b0000011, 7'b1100111, 7'b1110011: begin
                r.fmt = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            7'b0100011: begin
                r.fmt = FMT_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            7'b1100011: begin
                r.fmt = FMT_B;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                r.fmt = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            7'b1101111: begin
                r.fmt = FMT_J;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            7'b0110011: begin
                r.fmt = FMT_R;
            end
            default: begin
                r.fmt     = FMT_ILL;
                r.illegal = 1'b1;
            end
        endcase
        r.imm = sext32(imm32);
        return r;
    endfunction

    res_t in_res_p0;
    res_t out_p1;
    logic out_vld_p1;
    logic accept;
    logic out_free;

    always_comb begin
        in_res_p0 = decode(bus.in_instr, bus.in_tag);
    end

    assign out_free = bus.out_ready || !out_vld_p1;
    assign accept   = bus.in_valid && bus.in_ready;

`ifdef IMM_GEN_PIPE_SKID_EN
    res_t skid_p0;
    logic skid_vld_p0;

    // in_ready comes straight from a flop so upstream never sees a path from out_ready.
    assign bus.in_ready = !skid_vld_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_p1  <= 1'b0;
            out_p1      <= '0;
            skid_vld_p0 <= 1'b0;
        end else if (out_free) begin
            if (skid_vld_p0) begin
                out_p1      <= skid_p0;
                out_vld_p1  <= 1'b1;
                skid_vld_p0 <= 1'b0;
            end else if (accept) begin
                out_p1     <= in_res_p0;
                out_vld_p1 <= 1'b1;
            end else begin
                out_vld_p1 <= 1'b0;
            end
        end else if (accept) begin
            skid_vld_p0 <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !out_free) skid_p0 <= in_res_p0;
    end
`else
    assign bus.in_ready = out_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_p1 <= 1'b0;
            out_p1     <= '0;
        end else if (accept) begin
            out_p1     <= in_res_p0;
            out_vld_p1 <= 1'b1;
        end else if (bus.out_ready) begin
            out_vld_p1 <= 1'b0;
        end
    end
`endif

    // ---- output stage p1 ----
    assign bus.out_valid   = out_vld_p1;
    assign bus.out_imm     = out_p1.imm;
    assign bus.out_fmt     = out_p1.fmt;
    assign bus.out_tag     = out_p1.tag;
    assign bus.out_illegal = out_p1.illegal;

endmodule
